ysyx_23060332_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_23060332_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between IFU (read-only) and LSU (read/write).
//  Round-robin arbitration with one transaction outstanding at a time.
//  Rejects addresses outside 0x8000_0000..0x87FF_FFFF without touching memory.
//  Enforces a response timeout, so a missing memory response returns an error.
//  Sits between the IFU/LSU and the ysyx_23060332 memory wrapper.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  MASK_W   8    write byte-mask width
//  TIMEOUT  255  max cycles in ISSUE+WAIT before error response (>=2)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       reset; asynchronous, active-high
//  ifu_req_valid   in   1       IFU read request
//  ifu_req_ready   out  1       IFU request accepted this cycle
//  ifu_addr        in   ADDR_W  IFU read address
//  ifu_resp_valid  out  1       one-cycle IFU response pulse
//  ifu_rdata       out  DATA_W  IFU read data (valid with resp_valid)
//  ifu_resp_err    out  1       IFU access fault/timeout (with resp_valid)
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_addr        in   ADDR_W  LSU address
//  lsu_wen         in   1       1 = write, 0 = read
//  lsu_wdata       in   DATA_W  write data
//  lsu_wmask       in   MASK_W  write byte mask
//  lsu_resp_valid  out  1       one-cycle LSU response pulse
//  lsu_rdata       out  DATA_W  LSU read data
//  lsu_resp_err    out  1       LSU access fault/timeout
//  mem_req_valid   out  1       request to memory
//  mem_req_ready   in   1       memory accepts request
//  mem_wen         out  1       write enable
//  mem_addr        out  ADDR_W  address
//  mem_wdata       out  DATA_W  write data
//  mem_wmask       out  MASK_W  write mask
//  mem_resp_valid  in   1       memory response (may coincide with req_ready)
//  mem_rdata       in   DATA_W  memory read data
// BEHAVIOUR
//  Reset:
//   - state=IDLE; last_grant=LSU; all outputs, captured regs and counter = 0.
//   - Reset mid-transaction abandons it; no response is ever issued for it.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE:
//   - req_ready = 1 only for the granted requester, combinational on valid.
//   - Grant: only one valid -> that one; both valid -> requester != last_grant.
//   - On accept: latch owner/addr/wen/wdata/wmask; update last_grant.
//   - Next state: in-range -> ISSUE; out-of-range -> RESP with err=1, rdata=0.
//  ISSUE:
//   - mem_req_valid=1 with latched fields held stable until mem_req_ready.
//   - IFU owner: mem_wen=0, mem_wmask=0.
//   - ready & resp_valid same cycle -> capture rdata, go RESP.
//   - ready alone -> go WAIT.
//  WAIT:
//   - mem_resp_valid -> capture mem_rdata, err=0, go RESP.
//  Timeout:
//   - Counter clears on ISSUE entry, increments each ISSUE/WAIT cycle.
//   - Reaching TIMEOUT -> RESP with err=1, rdata=0.
//  RESP:
//   - Owner's resp_valid=1 for exactly one cycle with rdata/err; go IDLE.
//   - Writes also respond (rdata = captured mem_rdata).
//   - Other requester's resp_valid/ready stay 0.
//  mem_resp_valid in IDLE/RESP (late/stale) is ignored.
//  No requests accepted outside IDLE.
//  Latency:
//   - In-range, zero-wait memory: accept T, ISSUE T+1, resp_valid T+2.
//   - Out-of-range: accept T, resp_valid T+1.
// TESTING
//  1. IFU read 0x8000_0000, mem ready+resp same cycle, rdata 0x0000_0413
//     -> ifu_resp_valid 2 cycles after accept, rdata 0x413, err 0.
//  2. IFU and LSU valid together from reset -> IFU granted first, LSU next;
//     both held valid -> grants alternate IFU,LSU,IFU.
//  3. LSU write 0x8000_0010, wdata 0xDEADBEEF, wmask 0x0F
//     -> mem_wen=1 with exact fields, held until ready; lsu_resp_valid once.
//  4. LSU read 0x9000_0000 -> no mem_req_valid; lsu_resp_valid next cycle,
//     err=1, rdata=0.
//  5. mem_req_ready held 0 for 3 cycles, resp 2 cycles after ready
//     -> mem fields stable throughout, single response.
//  6. TIMEOUT=4, no mem_resp_valid -> err response 4 cycles after ISSUE;
//     late mem_resp_valid ignored. Assert rst in WAIT -> all outputs 0, IDLE.

Source files
------------

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Memory-port arbiter shared by the IFU (read-only) and the LSU (read/write).
// Round-robin grant, one transaction in flight, address-window filtering and
// a response timeout so a silent memory still produces an error response.
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LO  = ADDR_W'(64'h8000_0000);
    localparam logic [ADDR_W-1:0] ADDR_HI  = ADDR_W'(64'h87FF_FFFF);

    state_t            state;
    logic              last_lsu;
    logic              owner_lsu;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [CNT_W-1:0]  cnt;

    logic              gnt_ifu;
    logic              gnt_lsu;
    logic              accept;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;

    // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        gnt_ifu      = ifu_req_valid && (!lsu_req_valid || last_lsu);
        gnt_lsu      = lsu_req_valid && (!ifu_req_valid || !last_lsu);
        sel_addr     = gnt_lsu ? lsu_addr : ifu_addr;
        sel_in_range = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI);
    end

    assign ifu_req_ready  = (state == IDLE) && gnt_ifu;
    assign lsu_req_ready  = (state == IDLE) && gnt_lsu;
    assign accept         = ifu_req_ready || lsu_req_ready;

    // Response fields are shown only to the owner, and only during its pulse.
    assign ifu_resp_valid = resp_valid && !owner_lsu;
    assign lsu_resp_valid = resp_valid && owner_lsu;
    assign ifu_rdata      = ifu_resp_valid ? resp_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? resp_rdata : '0;
    assign ifu_resp_err   = ifu_resp_valid && resp_err;
    assign lsu_resp_err   = lsu_resp_valid && resp_err;

    // Transaction FSM: accept, issue to memory, wait for data or timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_lsu      <= 1'b1;
            owner_lsu     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_lsu <= gnt_lsu;
                        last_lsu  <= gnt_lsu;
                        mem_addr  <= sel_addr;
                        mem_wen   <= gnt_lsu && lsu_wen;
                        mem_wdata <= gnt_lsu ? lsu_wdata : '0;
                        mem_wmask <= gnt_lsu ? lsu_wmask : '0;
                        cnt       <= '0;
                        if (sel_in_range) begin
                            mem_req_valid <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + CNT_ONE;
                    if (mem_req_ready && mem_resp_valid) begin
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b0;
                        resp_rdata    <= mem_rdata;
                        state         <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_rdata    <= '0;
                        state         <= RESP;
                    end else if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_ONE;
                    if (mem_resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_rdata;
                        state      <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: a scripted memory model, a request
// driver pushing expected responses, and a monitor popping them on each pulse.
module tb_ysyx_23060332_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        lsu_req_valid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    // main instance (TIMEOUT 8) and timeout instance (TIMEOUT 4) share inputs
    logic        a_ifu_ready, a_ifu_rv, a_ifu_err, a_lsu_ready, a_lsu_rv, a_lsu_err;
    logic        a_mreq, a_mwen;
    logic [31:0] a_ifu_rdata, a_lsu_rdata, a_maddr, a_mwdata;
    logic [7:0]  a_mwmask;
    logic        b_ifu_ready, b_ifu_rv, b_ifu_err, b_lsu_ready, b_lsu_rv, b_lsu_err;
    logic        b_mreq, b_mwen;
    logic [31:0] b_ifu_rdata, b_lsu_rdata, b_maddr, b_mwdata;
    logic [7:0]  b_mwmask;

    logic        m_ifu_ready, m_ifu_rv, m_ifu_err, m_lsu_ready, m_lsu_rv, m_lsu_err;
    logic        m_mreq, m_mwen;
    logic [31:0] m_ifu_rdata, m_lsu_rdata, m_maddr, m_mwdata;
    logic [7:0]  m_mwmask;
    logic        sel = 1'b0;

    ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(a_ifu_rv), .ifu_rdata(a_ifu_rdata), .ifu_resp_err(a_ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(a_lsu_rv), .lsu_rdata(a_lsu_rdata), .lsu_resp_err(a_lsu_err),
        .mem_req_valid(a_mreq), .mem_req_ready(mem_req_ready), .mem_wen(a_mwen),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mwmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(b_ifu_rv), .ifu_rdata(b_ifu_rdata), .ifu_resp_err(b_ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(b_lsu_rv), .lsu_rdata(b_lsu_rdata), .lsu_resp_err(b_lsu_err),
        .mem_req_valid(b_mreq), .mem_req_ready(mem_req_ready), .mem_wen(b_mwen),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mwmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always_comb begin
        m_ifu_ready = sel ? b_ifu_ready : a_ifu_ready;
        m_lsu_ready = sel ? b_lsu_ready : a_lsu_ready;
        m_ifu_rv    = sel ? b_ifu_rv    : a_ifu_rv;
        m_ifu_rdata = sel ? b_ifu_rdata : a_ifu_rdata;
        m_ifu_err   = sel ? b_ifu_err   : a_ifu_err;
        m_lsu_rv    = sel ? b_lsu_rv    : a_lsu_rv;
        m_lsu_rdata = sel ? b_lsu_rdata : a_lsu_rdata;
        m_lsu_err   = sel ? b_lsu_err   : a_lsu_err;
        m_mreq      = sel ? b_mreq      : a_mreq;
        m_mwen      = sel ? b_mwen      : a_mwen;
        m_maddr     = sel ? b_maddr     : a_maddr;
        m_mwdata    = sel ? b_mwdata    : a_mwdata;
        m_mwmask    = sel ? b_mwmask    : a_mwmask;
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic lsu; logic [31:0] rdata; logic err; int cyc;} rsp_t;
    typedef struct {logic wen; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask;} mreq_t;
    rsp_t  sq[$];
    mreq_t mq[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // scripted memory behaviour
    int          ready_dly = 0;
    int          resp_dly = 0;
    logic [31:0] mem_val = '0;
    logic        late_resp = 1'b0;

    initial begin
        int    iss_cnt = 0;
        int    pend = 0;
        logic  have = 1'b0;
        mreq_t cur;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = late_resp;
            mem_rdata      = mem_val;
            if (rst) begin
                iss_cnt = 0;
                pend = 0;
            end else if (m_mreq) begin
                if (iss_cnt == 0) begin
                    if (mq.size() == 0) begin
                        check("mem_req_unexpected", 1, 0);
                        have = 1'b0;
                    end else begin
                        cur = mq.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    check("mem_wen", m_mwen, cur.wen);
                    check("mem_addr", m_maddr, cur.addr);
                    check("mem_wmask", m_mwmask, cur.wmask);
                    if (cur.wen) check("mem_wdata", m_mwdata, cur.wdata);
                end
                if (iss_cnt >= ready_dly) begin
                    mem_req_ready = 1'b1;
                    if (resp_dly == 0) mem_resp_valid = 1'b1;
                    else if (resp_dly > 0) pend = resp_dly;
                end
                iss_cnt++;
            end else begin
                iss_cnt = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) mem_resp_valid = 1'b1;
                end
            end
        end
    end

    // response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (m_ifu_rv || m_lsu_rv)) begin
                check("resp_one_owner", m_ifu_rv & m_lsu_rv, 0);
                if (sq.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e = sq.pop_front();
                    check("resp_owner_lsu", m_lsu_rv, e.lsu);
                    check("resp_rdata", e.lsu ? m_lsu_rdata : m_ifu_rdata, e.rdata);
                    check("resp_err", e.lsu ? m_lsu_err : m_ifu_err, e.err);
                    if (e.cyc >= 0) check("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        sq.delete();
        mq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet();
        check("q_mem_req_valid", m_mreq, 0);
        check("q_mem_wen", m_mwen, 0);
        check("q_mem_addr", m_maddr, 0);
        check("q_mem_wdata", m_mwdata, 0);
        check("q_mem_wmask", m_mwmask, 0);
        check("q_resp_valid", {m_ifu_rv, m_lsu_rv}, 0);
        check("q_rdata", {m_ifu_rdata, m_lsu_rdata}, 0);
        check("q_req_ready", {m_ifu_ready, m_lsu_ready}, 0);
    endtask

    // one request; pushes expectations once it sees ready, returns after the accept edge
    task automatic do_req(input logic lsu, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wd, input logic [7:0] wm, input int lat,
                          input logic exp_err, input logic push_rsp, output int t_acc);
        logic got;
        logic inr;
        got = 1'b0;
        @(negedge clk);
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if (lsu ? m_lsu_ready : m_ifu_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("req_accepted", got, 1);
        t_acc = cyc;
        inr = (addr >= 32'h8000_0000) && (addr <= 32'h87FF_FFFF);
        if (got) begin
            if (push_rsp) sq.push_back('{lsu, exp_err ? 32'h0 : mem_val, exp_err, t_acc + lat});
            if (inr) mq.push_back('{lsu & wen, addr, wd, lsu ? wm : 8'h00});
        end
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (sq.size() == 0 && mq.size() == 0 && !m_mreq) break;
        end
        check("drain_pending_resp", sq.size(), 0);
    endtask

    initial begin
        int       t;
        int       g;
        logic [2:0] order;
        logic     got_gnt;

        reset_all();
        #1;
        check_quiet();

        // IFU read, zero-wait memory
        mem_val = 32'h0000_0413; ready_dly = 0; resp_dly = 0;
        do_req(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 2, 1'b0, 1'b1, t);
        drain();

        // simultaneous requests from reset: IFU, LSU, IFU
        reset_all();
        mem_val = 32'h1111_2222;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 8'h00;
        order = 3'b010;
        g = 0;
        #1;
        for (int i = 0; i < 30 && g < 3; i++) begin
            if (m_ifu_ready || m_lsu_ready) begin
                check("grant_exclusive", m_ifu_ready & m_lsu_ready, 0);
                check("grant_order", m_lsu_ready, order[g]);
                sq.push_back('{order[g], mem_val, 1'b0, cyc + 2});
                mq.push_back('{1'b0, order[g] ? 32'h8000_0200 : 32'h8000_0100, 32'h0, 8'h00});
                g++;
            end
            if (g < 3) begin
                @(negedge clk);
                #1;
            end
        end
        got_gnt = (g == 3);
        check("grant_count", got_gnt, 1);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        drain();

        // LSU write held until ready, responds with captured mem_rdata
        mem_val = 32'h0BAD_F00D; ready_dly = 2; resp_dly = 0;
        do_req(1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F, 4, 1'b0, 1'b1, t);
        drain();

        // out-of-range reads: never reach memory, error next cycle
        ready_dly = 0;
        do_req(1'b1, 32'h9000_0000, 1'b0, 32'h0, 8'h00, 1, 1'b1, 1'b1, t);
        drain();
        do_req(1'b0, 32'h8800_0000, 1'b0, 32'h0, 8'h00, 1, 1'b1, 1'b1, t);
        drain();
        do_req(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 8'h00, 1, 1'b1, 1'b1, t);
        drain();
        // top edge of the window is in range
        mem_val = 32'hCAFE_0001;
        do_req(1'b1, 32'h87FF_FFFC, 1'b0, 32'h0, 8'h00, 2, 1'b0, 1'b1, t);
        drain();

        // slow memory: ready after 3 stalled cycles, data 2 cycles later
        mem_val = 32'h5555_AAAA; ready_dly = 3; resp_dly = 2;
        do_req(1'b1, 32'h8000_0040, 1'b1, 32'h0102_0304, 8'hF0, 7, 1'b0, 1'b1, t);
        drain();

        // timeout instance: silent memory gives error 4 cycles after ISSUE
        sel = 1'b1;
        reset_all();
        #1;
        check_quiet();
        mem_val = 32'h7777_7777; ready_dly = 0; resp_dly = -1;
        do_req(1'b0, 32'h8000_0080, 1'b0, 32'h0, 8'h00, 5, 1'b1, 1'b1, t);
        for (int i = 0; i < 20 && cyc < t + 5; i++) begin
            @(posedge clk);
            #1;
        end
        late_resp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        late_resp = 1'b0;
        drain();

        // reset while waiting: transaction abandoned, no response
        do_req(1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 1'b0, 1'b0, t);
        for (int i = 0; i < 20 && cyc < t + 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("in_flight_before_reset", sq.size() + mq.size(), 0);
        rst = 1'b1;
        #1;
        check_quiet();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        // arbiter is back in IDLE and serves a fresh request
        mem_val = 32'h0000_0ABC; resp_dly = 0;
        do_req(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 2, 1'b0, 1'b1, t);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
